// File: rtl/score_pkg.sv
// score_pkg: shared types and constants for the score_keeper block.
//   score_state_t - clear-processing FSM states (idle, level-scaled add, done pulse)
//   PTS_*         - base points per line-clear size
//   base_points() - maps a clear count to its base points, 0 for counts outside 1..4
package score_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAdd  = 2'd1,
        StDone = 2'd2
    } score_state_t;

    localparam int unsigned PTS_SINGLE = 40;
    localparam int unsigned PTS_DOUBLE = 100;
    localparam int unsigned PTS_TRIPLE = 300;
    localparam int unsigned PTS_TETRIS = 1200;

    // Wide enough for the largest base value (1200).
    localparam int unsigned BASE_WIDTH = 11;

    function automatic logic [BASE_WIDTH-1:0] base_points(input logic [2:0] count);
        logic [BASE_WIDTH-1:0] pts;
        case (count)
            3'd1:    pts = BASE_WIDTH'(PTS_SINGLE);
            3'd2:    pts = BASE_WIDTH'(PTS_DOUBLE);
            3'd3:    pts = BASE_WIDTH'(PTS_TRIPLE);
            3'd4:    pts = BASE_WIDTH'(PTS_TETRIS);
            default: pts = '0;
        endcase
        return pts;
    endfunction

endpackage

// File: rtl/score_keeper_if.sv
// score_keeper_if: bundle between the playfield controller (master) and score_keeper (slave).
//   game_reset   m->s  new-game restart, samples start_level
//   start_level  m->s  level loaded on game_reset
//   clear_valid  m->s  line-clear event valid (held until accepted)
//   clear_count  m->s  lines cleared by the event
//   drop_valid   m->s  one soft-drop point
//   clear_ready  s->m  block can accept a clear event
//   score        s->m  current score
//   lines        s->m  total lines cleared
//   level        s->m  current level
//   score_update s->m  one-cycle pulse when a clear's points are fully applied
interface score_keeper_if #(
    parameter int unsigned SCORE_WIDTH = 20,
    parameter int unsigned LINES_WIDTH = 12,
    parameter int unsigned LEVEL_WIDTH = 5
);

    logic                   game_reset;
    logic [LEVEL_WIDTH-1:0] start_level;
    logic                   clear_valid;
    logic [2:0]             clear_count;
    logic                   drop_valid;
    logic                   clear_ready;
    logic [SCORE_WIDTH-1:0] score;
    logic [LINES_WIDTH-1:0] lines;
    logic [LEVEL_WIDTH-1:0] level;
    logic                   score_update;

    modport master (
        output game_reset, start_level, clear_valid, clear_count, drop_valid,
        input  clear_ready, score, lines, level, score_update
    );

    modport slave (
        input  game_reset, start_level, clear_valid, clear_count, drop_valid,
        output clear_ready, score, lines, level, score_update
    );

endinterface

// File: rtl/score_keeper.sv
// score_keeper: Tetris scoring engine. Tracks score, total lines and level; line clears are
// scaled by (level+1) through repeated saturating additions, one per cycle.
//   clk_i   system clock
//   rst_ni  synchronous active-low reset
//   sk_bus  score_keeper_if.slave: clear handshake, soft drop, game restart and the
//           registered score/lines/level/score_update results
module score_keeper
    import score_pkg::*;
#(
    parameter int unsigned SCORE_WIDTH     = 20,
    parameter int unsigned SCORE_MAX       = 999_999,
    parameter int unsigned LINES_WIDTH     = 12,
    parameter int unsigned LEVEL_WIDTH     = 5,
    parameter int unsigned LINES_PER_LEVEL = 10,
    parameter int unsigned MAX_LEVEL       = 29
) (
    input logic          clk_i,
    input logic          rst_ni,
    score_keeper_if.slave sk_bus
);

    localparam int unsigned IterWidth = LEVEL_WIDTH + 1;
    // Holds lines-in-level plus one clear of up to 7 before the wrap is taken.
    localparam int unsigned LilWidth  = $clog2(LINES_PER_LEVEL + 8);

    localparam logic [SCORE_WIDTH:0]   ScoreMaxW = (SCORE_WIDTH + 1)'(SCORE_MAX);
    localparam logic [LEVEL_WIDTH-1:0] MaxLevelW = LEVEL_WIDTH'(MAX_LEVEL);
    localparam logic [LilWidth-1:0]    LplW      = LilWidth'(LINES_PER_LEVEL);

    score_state_t           state_q, state_d;
    logic [SCORE_WIDTH-1:0] score_q, score_d;
    logic [LINES_WIDTH-1:0] lines_q, lines_d;
    logic [LEVEL_WIDTH-1:0] level_q, level_d;
    logic [LilWidth-1:0]    lil_q, lil_d;
    logic [3:0]             drop_pend_q, drop_pend_d;
    logic [BASE_WIDTH-1:0]  base_q, base_d;
    logic [IterWidth-1:0]   iter_q, iter_d;
    logic                   update_q, update_d;

    logic                   accept;
    logic [BASE_WIDTH-1:0]  event_pts;
    logic [SCORE_WIDTH:0]   addend;
    logic [SCORE_WIDTH:0]   score_sum;
    logic [LINES_WIDTH:0]   lines_sum;
    logic [LilWidth-1:0]    lil_sum;
    logic [LEVEL_WIDTH-1:0] start_clamped;

    assign accept        = sk_bus.clear_valid && (state_q == StIdle);
    assign event_pts     = base_points(sk_bus.clear_count);
    assign start_clamped = (sk_bus.start_level > MaxLevelW) ? MaxLevelW : sk_bus.start_level;

    always_comb begin
        state_d     = state_q;
        lines_d     = lines_q;
        level_d     = level_q;
        lil_d       = lil_q;
        base_d      = base_q;
        iter_d      = iter_q;
        update_d    = 1'b0;
        addend      = '0;
        drop_pend_d = (drop_pend_q == 4'hF) ? drop_pend_q : drop_pend_q + 4'(sk_bus.drop_valid);
        lines_sum   = {1'b0, lines_q} + (LINES_WIDTH + 1)'(sk_bus.clear_count);
        lil_sum     = lil_q + LilWidth'(sk_bus.clear_count);

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    // Invalid counts are consumed without any effect.
                    if (event_pts != '0) begin
                        base_d  = event_pts;
                        iter_d  = IterWidth'(level_q) + IterWidth'(1);
                        lines_d = lines_sum[LINES_WIDTH] ? '1 : lines_sum[LINES_WIDTH-1:0];
                        if (lil_sum >= LplW) begin
                            lil_d = lil_sum - LplW;
                            if (level_q < MaxLevelW) begin
                                level_d = level_q + LEVEL_WIDTH'(1);
                            end
                        end else begin
                            lil_d = lil_sum;
                        end
                        state_d = StAdd;
                    end
                end else if (drop_pend_q != 4'd0) begin
                    addend      = (SCORE_WIDTH + 1)'(drop_pend_q);
                    // A drop arriving during the flush is kept for the next one.
                    drop_pend_d = {3'b000, sk_bus.drop_valid};
                end
            end
            StAdd: begin
                addend = (SCORE_WIDTH + 1)'(base_q);
                iter_d = iter_q - IterWidth'(1);
                if (iter_q == IterWidth'(1)) begin
                    state_d  = StDone;
                    update_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // One extra bit so the sum can exceed the ceiling before it is clamped.
        score_sum = {1'b0, score_q} + addend;
        score_d   = (score_sum > ScoreMaxW) ? ScoreMaxW[SCORE_WIDTH-1:0]
                                            : score_sum[SCORE_WIDTH-1:0];

        if (sk_bus.game_reset) begin
            state_d     = StIdle;
            score_d     = '0;
            lines_d     = '0;
            level_d     = start_clamped;
            lil_d       = '0;
            drop_pend_d = '0;
            base_d      = '0;
            iter_d      = '0;
            update_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            score_q     <= '0;
            lines_q     <= '0;
            level_q     <= '0;
            lil_q       <= '0;
            drop_pend_q <= '0;
            base_q      <= '0;
            iter_q      <= '0;
            update_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            lines_q     <= lines_d;
            level_q     <= level_d;
            lil_q       <= lil_d;
            drop_pend_q <= drop_pend_d;
            base_q      <= base_d;
            iter_q      <= iter_d;
            update_q    <= update_d;
        end
    end

    assign sk_bus.clear_ready  = (state_q == StIdle);
    assign sk_bus.score        = score_q;
    assign sk_bus.lines        = lines_q;
    assign sk_bus.level        = level_q;
    assign sk_bus.score_update = update_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: drives two score_keeper instances from the same stimulus, one with the
// default score ceiling and one with a ceiling of 1000, and checks both against a
// cycle-level behavioural model of the scoring rules.
module tb_score_keeper;

    localparam int unsigned SW    = 20;
    localparam int unsigned LW    = 12;
    localparam int unsigned VW    = 5;
    localparam int unsigned MAX_A = 999_999;
    localparam int unsigned MAX_B = 1000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          game_reset = 1'b0;
    logic [VW-1:0] start_level = '0;
    logic          clear_valid = 1'b0;
    logic [2:0]    clear_count = '0;
    logic          drop_valid = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    score_keeper_if #(.SCORE_WIDTH(SW), .LINES_WIDTH(LW), .LEVEL_WIDTH(VW)) bus_a ();
    score_keeper_if #(.SCORE_WIDTH(SW), .LINES_WIDTH(LW), .LEVEL_WIDTH(VW)) bus_b ();

    assign bus_a.game_reset  = game_reset;
    assign bus_a.start_level = start_level;
    assign bus_a.clear_valid = clear_valid;
    assign bus_a.clear_count = clear_count;
    assign bus_a.drop_valid  = drop_valid;
    assign bus_b.game_reset  = game_reset;
    assign bus_b.start_level = start_level;
    assign bus_b.clear_valid = clear_valid;
    assign bus_b.clear_count = clear_count;
    assign bus_b.drop_valid  = drop_valid;

    score_keeper #(
        .SCORE_WIDTH(SW), .SCORE_MAX(MAX_A), .LINES_WIDTH(LW), .LEVEL_WIDTH(VW),
        .LINES_PER_LEVEL(10), .MAX_LEVEL(29)
    ) dut_a (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .sk_bus (bus_a)
    );

    score_keeper #(
        .SCORE_WIDTH(SW), .SCORE_MAX(MAX_B), .LINES_WIDTH(LW), .LEVEL_WIDTH(VW),
        .LINES_PER_LEVEL(10), .MAX_LEVEL(29)
    ) dut_b (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .sk_bus (bus_b)
    );

    // ---------------- behavioural model ----------------
    // m_busy counts cycles left before the block is idle again: a clear at level L keeps
    // it busy for L+1 add cycles plus the done cycle. The score is compared only outside
    // the add phase, where it must equal the full level-scaled award (clamped).
    int     pts_tab [8] = '{0, 40, 100, 300, 1200, 0, 0, 0};
    int     m_busy, m_lines, m_level, m_lil, m_pend;
    longint m_score [2];
    longint m_target [2];
    longint smax [2] = '{longint'(MAX_A), longint'(MAX_B)};

    function automatic longint lmin(input longint a, input longint b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_clear_all(input int lvl);
        m_busy  = 0;
        m_lines = 0;
        m_level = lvl;
        m_lil   = 0;
        m_pend  = 0;
        for (int i = 0; i < 2; i++) begin
            m_score[i]  = 0;
            m_target[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit idle;
        bit acc;
        int pts;
        int cnt;
        if (!rst_n) begin
            model_clear_all(0);
        end else if (game_reset) begin
            model_clear_all((int'(start_level) > 29) ? 29 : int'(start_level));
        end else begin
            idle = (m_busy == 0);
            acc  = clear_valid && idle;
            cnt  = int'(clear_count);
            pts  = pts_tab[cnt];
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 1) begin
                    for (int i = 0; i < 2; i++) m_score[i] = m_target[i];
                end
            end
            if (idle && !acc && m_pend != 0) begin
                for (int i = 0; i < 2; i++) m_score[i] = lmin(m_score[i] + m_pend, smax[i]);
                m_pend = int'(drop_valid);
            end else begin
                m_pend = (m_pend + int'(drop_valid) > 15) ? 15 : m_pend + int'(drop_valid);
            end
            if (acc && pts != 0) begin
                for (int i = 0; i < 2; i++) begin
                    m_target[i] = lmin(m_score[i] + longint'(pts) * (m_level + 1), smax[i]);
                end
                m_busy  = m_level + 2;
                m_lines = (m_lines + cnt > 4095) ? 4095 : m_lines + cnt;
                m_lil   = m_lil + cnt;
                if (m_lil >= 10) begin
                    m_lil = m_lil - 10;
                    if (m_level < 29) m_level++;
                end
            end
        end
    endtask

    // Advance one clock, update the model with the inputs seen at that edge, and settle.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic new_game(input int lvl);
        game_reset  = 1'b1;
        start_level = VW'(lvl);
        step();
        game_reset  = 1'b0;
    endtask

    // Present one clear, then run until clear_ready returns. pulse is the number of edges
    // after the accept edge at which score_update was seen (-1 if never); low counts the
    // cycles clear_ready stayed low. A hang leaves low at 64 and pulse at -1.
    task automatic run_clear(input int cnt, output int pulse, output int low,
                             output int sa, output int sb);
        clear_valid = 1'b1;
        clear_count = 3'(cnt);
        step();
        clear_valid = 1'b0;
        pulse = -1;
        low   = 0;
        sa    = -1;
        sb    = -1;
        for (int s = 0; s < 64; s++) begin
            if (bus_a.score_update && pulse < 0) begin
                pulse = s;
                sa    = int'(bus_a.score);
                sb    = int'(bus_b.score);
            end
            if (bus_a.clear_ready) break;
            low++;
            step();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (bus_a.score !== '0) begin failures++;
            $display("FAIL reset_score got=%0d exp=0", bus_a.score); end
        checks++; if (bus_a.lines !== '0) begin failures++;
            $display("FAIL reset_lines got=%0d exp=0", bus_a.lines); end
        checks++; if (bus_a.level !== '0) begin failures++;
            $display("FAIL reset_level got=%0d exp=0", bus_a.level); end
        checks++; if (bus_a.score_update !== 1'b0) begin failures++;
            $display("FAIL reset_update got=%b exp=0", bus_a.score_update); end
        rst_n = 1'b1;
        step();
        checks++; if (bus_a.clear_ready !== 1'b1) begin failures++;
            $display("FAIL reset_ready got=%b exp=1", bus_a.clear_ready); end
    endtask

    task automatic test_tetris_level0();
        int pulse, low, sa, sb;
        new_game(0);
        run_clear(4, pulse, low, sa, sb);
        checks++; if (pulse != 1) begin failures++;
            $display("FAIL tetris_pulse_time got=%0d exp=1", pulse); end
        checks++; if (low != 2) begin failures++;
            $display("FAIL tetris_busy_cycles got=%0d exp=2", low); end
        checks++; if (sa != 1200) begin failures++;
            $display("FAIL tetris_score got=%0d exp=1200", sa); end
        checks++; if (sb != 1000) begin failures++;
            $display("FAIL tetris_score_sat got=%0d exp=1000", sb); end
        checks++; if (bus_a.lines !== LW'(4)) begin failures++;
            $display("FAIL tetris_lines got=%0d exp=4", bus_a.lines); end
        checks++; if (bus_a.level !== VW'(0)) begin failures++;
            $display("FAIL tetris_level got=%0d exp=0", bus_a.level); end
    endtask

    task automatic test_start_level2();
        int pulse, low, sa, sb;
        new_game(2);
        run_clear(1, pulse, low, sa, sb);
        checks++; if (pulse != 3) begin failures++;
            $display("FAIL lvl2_pulse_time got=%0d exp=3", pulse); end
        checks++; if (low != 4) begin failures++;
            $display("FAIL lvl2_ready_low got=%0d exp=4", low); end
        checks++; if (sa != 120) begin failures++;
            $display("FAIL lvl2_score got=%0d exp=120", sa); end
    endtask

    task automatic test_level_up();
        int pulse, low, sa, sb;
        new_game(0);
        for (int i = 0; i < 10; i++) run_clear(1, pulse, low, sa, sb);
        checks++; if (bus_a.lines !== LW'(10)) begin failures++;
            $display("FAIL levelup_lines got=%0d exp=10", bus_a.lines); end
        checks++; if (bus_a.level !== VW'(1)) begin failures++;
            $display("FAIL levelup_level got=%0d exp=1", bus_a.level); end
        checks++; if (bus_a.score !== SW'(400)) begin failures++;
            $display("FAIL levelup_score got=%0d exp=400", bus_a.score); end
        run_clear(1, pulse, low, sa, sb);
        checks++; if (sa != 480) begin failures++;
            $display("FAIL levelup_11th_score got=%0d exp=480", sa); end
        checks++; if (pulse != 2) begin failures++;
            $display("FAIL levelup_11th_pulse got=%0d exp=2", pulse); end
    endtask

    task automatic test_saturation_and_noop();
        int pulse, low, sa, sb;
        new_game(0);
        run_clear(4, pulse, low, sa, sb);
        run_clear(4, pulse, low, sa, sb);
        checks++; if (bus_b.score !== SW'(1000)) begin failures++;
            $display("FAIL sat_score got=%0d exp=1000", bus_b.score); end
        checks++; if (bus_a.score !== SW'(2400)) begin failures++;
            $display("FAIL unsat_score got=%0d exp=2400", bus_a.score); end
        run_clear(0, pulse, low, sa, sb);
        checks++; if (pulse != -1 || low != 0) begin failures++;
            $display("FAIL noop0_handshake got=pulse%0d/low%0d exp=pulse-1/low0", pulse, low); end
        run_clear(6, pulse, low, sa, sb);
        checks++; if (pulse != -1 || low != 0) begin failures++;
            $display("FAIL noop6_handshake got=pulse%0d/low%0d exp=pulse-1/low0", pulse, low); end
        checks++; if (bus_a.score !== SW'(2400) || bus_a.lines !== LW'(8)) begin failures++;
            $display("FAIL noop_state got=score%0d/lines%0d exp=score2400/lines8",
                     bus_a.score, bus_a.lines); end
    endtask

    task automatic test_drop();
        new_game(0);
        // Drops on the accept, add and done edges all land in the pending counter.
        clear_valid = 1'b1;
        clear_count = 3'd1;
        drop_valid  = 1'b1;
        step();
        clear_valid = 1'b0;
        step();
        checks++; if (bus_a.score_update !== 1'b1 || bus_a.score !== SW'(40)) begin failures++;
            $display("FAIL drop_done got=upd%b/score%0d exp=upd1/score40",
                     bus_a.score_update, bus_a.score); end
        step();
        checks++; if (bus_a.clear_ready !== 1'b1 || bus_a.score !== SW'(40)) begin failures++;
            $display("FAIL drop_idle got=rdy%b/score%0d exp=rdy1/score40",
                     bus_a.clear_ready, bus_a.score); end
        // Flush edge with a fresh pulse: 3 applied now, the new one kept.
        step();
        checks++; if (bus_a.score !== SW'(43)) begin failures++;
            $display("FAIL drop_flush got=%0d exp=43", bus_a.score); end
        drop_valid = 1'b0;
        step();
        checks++; if (bus_a.score !== SW'(44)) begin failures++;
            $display("FAIL drop_kept_pulse got=%0d exp=44", bus_a.score); end
        checks++; if (bus_a.score_update !== 1'b0) begin failures++;
            $display("FAIL drop_no_update got=%b exp=0", bus_a.score_update); end
    endtask

    task automatic test_game_reset_mid_add();
        int pulses;
        new_game(5);
        clear_valid = 1'b1;
        clear_count = 3'd4;
        step();
        clear_valid = 1'b0;
        step();
        step();
        checks++; if (bus_a.clear_ready !== 1'b0) begin failures++;
            $display("FAIL abort_busy got=%b exp=0", bus_a.clear_ready); end
        game_reset  = 1'b1;
        start_level = 5'd7;
        step();
        game_reset  = 1'b0;
        checks++; if (bus_a.score !== '0 || bus_a.lines !== '0) begin failures++;
            $display("FAIL abort_clear got=score%0d/lines%0d exp=0/0", bus_a.score, bus_a.lines); end
        checks++; if (bus_a.level !== VW'(7)) begin failures++;
            $display("FAIL abort_level got=%0d exp=7", bus_a.level); end
        checks++; if (bus_a.clear_ready !== 1'b1) begin failures++;
            $display("FAIL abort_ready got=%b exp=1", bus_a.clear_ready); end
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus_a.score_update) pulses++;
            step();
        end
        checks++; if (pulses != 0) begin failures++;
            $display("FAIL abort_no_update got=%0d exp=0", pulses); end
        new_game(5);
        clear_valid = 1'b1;
        clear_count = 3'd2;
        step();
        clear_valid = 1'b0;
        game_reset  = 1'b1;
        start_level = 5'd31;
        step();
        game_reset  = 1'b0;
        checks++; if (bus_a.level !== VW'(29)) begin failures++;
            $display("FAIL start_clamp got=%0d exp=29", bus_a.level); end
    endtask

    task automatic test_random();
        bit ready_now;
        new_game(0);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            drop_valid = ($urandom_range(0, 3) == 0);
            game_reset = ($urandom_range(0, 299) == 0);
            if (game_reset) start_level = VW'($urandom_range(0, 31));
            if (!clear_valid && $urandom_range(0, 2) == 0) begin
                clear_valid = 1'b1;
                if ($urandom_range(0, 9) == 0) clear_count = ($urandom_range(0, 1) == 0) ? 3'd0
                                                            : 3'($urandom_range(5, 7));
                else clear_count = 3'($urandom_range(1, 4));
            end
            ready_now = bus_a.clear_ready;
            step();
            if (clear_valid && (ready_now || game_reset)) clear_valid = 1'b0;

            checks++; if (bus_a.clear_ready !== (m_busy == 0)) begin failures++;
                $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, bus_a.clear_ready,
                         (m_busy == 0)); end
            checks++; if (bus_a.score_update !== (m_busy == 1)) begin failures++;
                $display("FAIL rnd_update cyc=%0d got=%b exp=%b", cyc, bus_a.score_update,
                         (m_busy == 1)); end
            checks++; if (bus_a.lines !== LW'(m_lines) || bus_a.level !== VW'(m_level)) begin
                failures++;
                $display("FAIL rnd_lines_level cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc,
                         bus_a.lines, bus_a.level, m_lines, m_level); end
            if (m_busy <= 1) begin
                checks++; if (bus_a.score !== SW'(m_score[0])) begin failures++;
                    $display("FAIL rnd_score cyc=%0d got=%0d exp=%0d", cyc, bus_a.score,
                             m_score[0]); end
                checks++; if (bus_b.score !== SW'(m_score[1])) begin failures++;
                    $display("FAIL rnd_score_sat cyc=%0d got=%0d exp=%0d", cyc, bus_b.score,
                             m_score[1]); end
            end
        end
        clear_valid = 1'b0;
        drop_valid  = 1'b0;
        game_reset  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tetris_level0();
        test_start_level2();
        test_level_up();
        test_saturation_and_noop();
        test_drop();
        test_game_reset_mid_add();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/score_keeper.md
# score_keeper

Sequential scoring engine for the Tetris game logic. It accepts line-clear events and soft-drop points from the playfield controller and maintains the binary score, total lines cleared and current level. The `score` output feeds `bin_to_bcd` directly for the score display, and `level` also feeds the gravity timer. Level-scaled points are computed by repeated saturating addition, so the block needs no multiplier or divider.

## Interface
- `SCORE_WIDTH`, 20: width of `score`.
- `SCORE_MAX`, 999_999: score saturation ceiling; must be < 2**SCORE_WIDTH.
- `LINES_WIDTH`, 12: width of `lines`; saturates at all-ones.
- `LEVEL_WIDTH`, 5: width of `level`/`start_level`.
- `LINES_PER_LEVEL`, 10: lines per level increment.
- `MAX_LEVEL`, 29: level ceiling.
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `game_reset`  in  1  synchronous new-game restart; samples `start_level`.
- `start_level`  in  LEVEL_WIDTH  level loaded on `game_reset`, clamped to MAX_LEVEL.
- `clear_valid`  in  1  line-clear event valid.
- `clear_count`  in  3  lines cleared by the event (1..4 meaningful).
- `clear_ready`  out  1  high only in IDLE.
- `drop_valid`  in  1  one soft-drop point, single-cycle pulse.
- `score`  out  SCORE_WIDTH  current score.
- `lines`  out  LINES_WIDTH  total lines cleared.
- `level`  out  LEVEL_WIDTH  current level.
- `score_update`  out  1  one-cycle pulse when a clear's points are fully applied.

## Operation
- States: IDLE, ADD, DONE. Reset and `game_reset` both enter IDLE.
- `rst_n` low: score=0, lines=0, level=0, internal lines-in-level counter=0, drop_pend=0, score_update=0, state IDLE. `clear_ready`=1 in the cycle after reset is released.
- `game_reset` (when `rst_n` is high): same as reset except level=min(`start_level`, MAX_LEVEL). It has priority over all events and aborts ADD/DONE. No `score_update` is emitted.
- Handshake: an event is accepted when `clear_valid && clear_ready`. The upstream must hold `clear_valid` and `clear_count` stable until accepted.
- Base points: 1→40, 2→100, 3→300, 4→1200. Counts 0 or 5..7 are accepted as no-ops: no score, lines or level change, no pulse, stay in IDLE.
- On a valid accept:
  - Latch base = table[`clear_count`] and iter = level+1, using the level *before* this clear.
  - lines += count, saturating.
  - Lines-in-level counter += count. If it reaches ≥ LINES_PER_LEVEL, subtract LINES_PER_LEVEL and increment level, capped at MAX_LEVEL. At most one level increment per event.
  - Go to ADD.
- ADD: each cycle score = min(score+base, SCORE_MAX) and iter -= 1. When iter reaches 0 after the add, go to DONE.
- DONE: `score_update`=1 for this cycle only, then IDLE.
- Soft drop: `drop_valid` increments drop_pend (4 bits, saturating at 15) in any state.
  - In IDLE, when drop_pend≠0 and no clear is accepted this cycle, score = min(score+drop_pend, SCORE_MAX). drop_pend then becomes `drop_valid` (a same-cycle pulse is kept, not lost).
  - The drop flush does not pulse `score_update`.
- All score arithmetic is done at SCORE_WIDTH+1 bits before compare and clamp, so no wrap-around is possible.

## Timing
- Accept at edge T. ADD occupies level+1 cycles, then one DONE cycle. `score_update` is high in cycle T+level+2, and `clear_ready` rises again in cycle T+level+3.
- `lines`/`level` update at the accept edge. `score` steps once per ADD cycle.
- Worst case: 30 ADD cycles at MAX_LEVEL=29.
- All outputs are registered. There is no combinational path from inputs to outputs except `clear_ready`, which is state-decoded only.

## Structure
- Package `score_pkg`:
  - state enum `score_state_t` (IDLE/ADD/DONE);
  - base-point constants `PTS_SINGLE`, `PTS_DOUBLE`, `PTS_TRIPLE`, `PTS_TETRIS`;
  - function `base_points(count)` returning 0 for invalid counts.
- Single module. No sub-module is natural; the saturating adder is an inline expression.

## Test plan
- Reset, `game_reset` with `start_level`=0, clear 4 → `score_update` 2 cycles after accept; score=1200, lines=4, level=0.
- `start_level`=2, clear 1 → 3 ADD cycles; score=120, pulse at accept+4, `clear_ready` low for 4 cycles.
- Ten single clears from level 0 → lines=10, level=1, score=400. The 11th single adds 80.
- Bench with SCORE_MAX=1000: two clears of 4 at level 0 → score=1000, no wrap. `clear_count`=0 or 6 → accepted, no change, no pulse.
- Three `drop_valid` pulses during ADD of a 1-line clear at level 0 → score 40 at DONE, 43 one cycle after returning to IDLE. A drop pulse in the same IDLE cycle as a flush is applied on the next cycle.
- `game_reset` asserted mid-ADD at level 5 → next cycle: score=0, lines=0, level=`start_level`, IDLE, no `score_update`. A `start_level` of 31 clamps to 29.
